// File: rtl/posit_encoder_32_3.sv
// posit(32,3) encoder: decoded fields in, packed posit out.
// Three-stage valid/ready pipeline with RNE rounding and saturation.
module posit_encoder_32_3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [5:0]  in_k,
  input  logic [2:0]  in_expo,
  input  logic [25:0] in_frac,
  input  logic        in_zero,
  input  logic        in_nar,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_posit
);

  localparam int N  = 32;
  localparam int ES = 3;
  localparam int FS = 26;
  localparam int KW = 6;

  localparam logic signed [KW-1:0] KMAX = 6'sd30;
  localparam logic signed [KW-1:0] KMIN = -6'sd30;

  typedef struct packed {
    logic          v;
    logic          sign;
    logic          zero;
    logic          nar;
    logic [KW-1:0] k;
    logic [ES-1:0] expo;
    logic [FS-1:0] frac;
    logic [5:0]    rl;
  } s1_t;

  typedef struct packed {
    logic         v;
    logic         sign;
    logic         zero;
    logic         nar;
    logic [N-2:0] body;
  } s2_t;

  s1_t s1, s1_d;
  s2_t s2, s2_d;
  logic [N-1:0] res;
  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  logic signed [KW-1:0] kin;
  assign kin = in_k;

  always_comb begin
    s1_d      = '0;
    s1_d.v    = in_valid;
    s1_d.sign = in_sign;
    s1_d.zero = in_zero;
    s1_d.nar  = in_nar;
    s1_d.k    = in_k;
    s1_d.expo = in_expo;
    s1_d.frac = in_frac;
    if (kin > KMAX) begin
      s1_d.k    = KMAX;
      s1_d.expo = '1;
      s1_d.frac = '1;
    end else if (kin < KMIN) begin
      s1_d.k    = KMIN;
      s1_d.expo = '0;
      s1_d.frac = '0;
    end
    // rl reaches 32 for k=30; 6 bits hold it
    if (s1_d.k[KW-1])
      s1_d.rl = 6'd1 - s1_d.k;
    else
      s1_d.rl = s1_d.k + 6'd2;
  end

  logic [31:0]  regime;
  logic [63:0]  rstr;
  logic [N-2:0] body;
  logic [5:0]   kp1;
  logic [5:0]   nk;
  logic         guard;
  logic         sticky;
  logic         rnd;

  always_comb begin
    kp1 = s1.k + 6'd1;
    nk  = 6'd0 - s1.k;
    if (s1.k[KW-1])
      regime = 32'h8000_0000 >> nk;
    else
      regime = ~(32'hffff_ffff >> kp1);
    rstr   = {regime, 32'h0}
           | ({s1.expo, s1.frac, 35'h0} >> s1.rl);
    body   = rstr[63:33];
    guard  = rstr[32];
    sticky = |rstr[31:0];
    rnd    = guard & (body[0] | sticky) & ~&body;

    s2_d      = '0;
    s2_d.v    = s1.v;
    s2_d.sign = s1.sign;
    s2_d.zero = s1.zero;
    s2_d.nar  = s1.nar;
    s2_d.body = body + {30'h0, rnd};
    if (s2_d.body == '0)
      s2_d.body = 31'h1;
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      s2.nar:
        res = 32'h8000_0000;
      !s2.nar && s2.zero:
        res = 32'h0;
      !s2.nar && !s2.zero && s2.sign:
        res = 32'h0 - {1'b0, s2.body};
      default:
        res = {1'b0, s2.body};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_posit <= '0;
    end else if (adv) begin
      s1        <= s1_d;
      s2        <= s2_d;
      out_valid <= s2.v;
      out_posit <= res;
    end
  end

endmodule

// File: tb/tb_posit_encoder_32_3.sv
// Bench for posit_encoder_32_3: bit-string reference model,
// scoreboard, stall/latency/reset checks, random traffic.
module tb_posit_encoder_32_3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_k;
  logic [2:0]  in_expo;
  logic [25:0] in_frac;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;

  always #5 clk = ~clk;

  posit_encoder_32_3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_k      (in_k),
    .in_expo   (in_expo),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  typedef struct {
    logic [31:0] v;
    int          c;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_p = '0;

  // Value-level reference: lay out the posit bit string, then round.
  function automatic logic [31:0] model(
    input bit s, input logic [5:0] k, input logic [2:0] e,
    input logic [25:0] f, input bit z, input bit n);
    int          kk;
    bit          bits[$];
    logic [30:0] body;
    bit          guard;
    bit          sticky;
    logic [31:0] p;
    if (n) return 32'h8000_0000;
    if (z) return 32'h0;
    kk = int'($signed(k));
    if (kk > 30) begin
      kk = 30; e = 3'h7; f = 26'h3ff_ffff;
    end else if (kk < -30) begin
      kk = -30; e = 3'h0; f = 26'h0;
    end
    if (kk >= 0) begin
      for (int i = 0; i <= kk; i++) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      for (int i = 0; i < -kk; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
    for (int i = 25; i >= 0; i--) bits.push_back(f[i]);
    while (bits.size() < 64) bits.push_back(1'b0);
    body = '0;
    for (int i = 0; i < 31; i++) body = {body[29:0], bits[i]};
    guard  = bits[31];
    sticky = 1'b0;
    for (int i = 32; i < bits.size(); i++) sticky |= bits[i];
    if (guard && (body[0] || sticky) && body != 31'h7fff_ffff)
      body = body + 31'h1;
    if (body == 31'h0) body = 31'h1;
    p = {1'b0, body};
    if (s) p = -p;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic step(
    input bit iv, input bit s, input logic [5:0] k,
    input logic [2:0] e, input logic [25:0] f, input bit z,
    input bit n, input bit ordy, input bit use_lit,
    input logic [31:0] lit, input bit lt, output bit acc);
    exp_t x;
    in_valid  = iv;
    in_sign   = s;
    in_k      = k;
    in_expo   = e;
    in_frac   = f;
    in_zero   = z;
    in_nar    = n;
    out_ready = ordy;
    acc       = 1'b0;
    #1;
    if (rst_n) begin
      chk("in_ready", 32'(in_ready),
          32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'h1);
        chk("stall_hold", out_posit, prev_p);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want none",
                   out_posit);
        end else begin
          x = q.pop_front();
          chk("data", out_posit, x.v);
          if (x.lat) chk("latency", 32'(cyc - x.c), 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        x.v = use_lit ? lit : model(s, k, e, f, z, n);
        x.c = cyc;
        x.lat = lt;
        q.push_back(x);
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = out_posit;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    bit a;
    step(0, 0, '0, '0, '0, 0, 0, ordy, 0, '0, 0, a);
  endtask

  task automatic send(input string name, input bit s,
                      input logic [5:0] k, input logic [2:0] e,
                      input logic [25:0] f, input bit z, input bit n,
                      input logic [31:0] lit);
    bit a;
    chk({"model_", name}, model(s, k, e, f, z, n), lit);
    step(1, s, k, e, f, z, n, 1, 1, lit, 1, a);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 50) begin
      idle(1);
      t++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
    end
  endtask

  initial begin
    bit a;
    int nacc;
    int j;
    rst_n     = 1'b0;
    in_valid  = 0;
    in_sign   = 0;
    in_k      = '0;
    in_expo   = '0;
    in_frac   = '0;
    in_zero   = 0;
    in_nar    = 0;
    out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_posit", out_posit, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    send("one", 0, 6'd0, 3'd0, 26'h0, 0, 0, 32'h4000_0000);
    send("neg_one", 1, 6'd0, 3'd0, 26'h0, 0, 0, 32'hc000_0000);
    send("k30", 0, 6'd30, 3'd5, 26'h123, 0, 0, 32'h7fff_ffff);
    send("k31", 0, 6'd31, 3'd0, 26'h0, 0, 0, 32'h7fff_ffff);
    send("k_m32", 1, 6'h20, 3'd6, 26'h55, 0, 0, 32'hffff_ffff);
    send("k_m31", 0, 6'h21, 3'd3, 26'h2aa_aaaa, 0, 0,
         32'h0000_0001);
    send("tie_even", 0, 6'd1, 3'd0, 26'h1, 0, 0, 32'h6000_0000);
    send("tie_odd", 0, 6'd1, 3'd0, 26'h3, 0, 0, 32'h6000_0002);
    send("no_round", 0, 6'd1, 3'd0, 26'h2, 0, 0, 32'h6000_0001);
    send("nar", 1, 6'd4, 3'd1, 26'h7, 1, 1, 32'h8000_0000);
    send("zero", 1, 6'd4, 3'd1, 26'h7, 1, 0, 32'h0000_0000);
    drain();

    // 8 back-to-back items against a 1,0,0 ready pattern
    nacc = 0;
    j = 0;
    while (nacc < 8 && j < 100) begin
      step(1, 1'($urandom), 6'($urandom), 3'($urandom),
           26'($urandom), 0, 0, (j % 3) == 0, 0, '0, 0, a);
      if (a) nacc++;
      j++;
    end
    chk("stream_accepts", 32'(nacc), 32'd8);
    drain();

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 6'($urandom),
           3'($urandom), 26'($urandom),
           ($urandom % 16) == 0, ($urandom % 32) == 0,
           ($urandom % 3) != 0, 0, '0, 0, a);
    end
    drain();

    // reset with three items in flight
    send("rs_a", 0, 6'd2, 3'd1, 26'h0, 0, 0, 32'h7100_0000);
    send("rs_b", 0, 6'd0, 3'd0, 26'h0, 0, 0, 32'h4000_0000);
    send("rs_c", 1, 6'd0, 3'd0, 26'h0, 0, 0, 32'hc000_0000);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_posit", out_posit, 32'h0);
    q.delete();
    prev_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send("post_rst", 0, 6'h3f, 3'd0, 26'h0, 0, 0, 32'h2000_0000);
    drain();
    repeat (6) idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
